// File: rtl/sevenseg_scan_driver_if.sv
// Bus between the BCD producer and the seven-segment scan driver.
// The producer drives value/control; the driver returns the pin-level scan outputs.
interface sevenseg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   bcd;
    logic                  lz_blank;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;
    logic                  pending;

    modport master (
        output en, load, bcd, lz_blank,
        input  seg, an, frame_done, pending
    );

    modport slave (
        input  en, load, bcd, lz_blank,
        output seg, an, frame_done, pending
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with leading-zero blanking and
// frame-aligned (tear-free) display updates.
module sevenseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    sevenseg_scan_driver_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b1001111;
        endcase
        return s;
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BW-1:0]     pend_q, pend_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic              pending_q, pending_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              fd_q, fd_d;

    logic              tick;
    logic              wrap;
    logic              run_zero;
    logic              blank;
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] zero_from;

    always_comb begin
        tick = bus.en && (presc_q == PRESC_TC);
        wrap = tick && (idx_q == IDX_LAST);

        presc_d = presc_q;
        if (bus.en) presc_d = tick ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

        // A load landing on the wrap edge bypasses PEND so it shows this frame.
        pend_d = bus.load ? bus.bcd : pend_q;
        disp_d = disp_q;
        if (wrap) begin
            if (bus.load)      disp_d = bus.bcd;
            else if (pending_q) disp_d = pend_q;
        end
        pending_d = wrap ? 1'b0 : (bus.load ? 1'b1 : pending_q);

        // zero_from[i]: every displayed digit from the top down to i is zero.
        run_zero  = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero && (disp_q[4*i +: 4] == 4'd0);
            zero_from[i] = run_zero;
        end

        cur_digit = disp_q[4*idx_q +: 4];
        blank     = bus.lz_blank && (idx_q != '0) && zero_from[idx_q];

        an_d = '0;
        if (bus.en) an_d[idx_q] = 1'b1;
        seg_d = (bus.en && !blank) ? decode(cur_digit) : 7'd0;
        fd_d  = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= '0;
            an_q      <= '0;
            fd_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: a frame-arithmetic model predicts each cycle's outputs for a
// 4-digit/div-4 driver and a 1-digit/div-1 driver sharing the same stimulus.
module tb_sevenseg_scan_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic        load;
    logic        lz;
    logic [15:0] bcd;

    sevenseg_scan_driver_if #(.DIGITS(4)) bus4 ();
    sevenseg_scan_driver_if #(.DIGITS(1)) bus1 ();

    assign bus4.en       = en;
    assign bus4.load     = load;
    assign bus4.bcd      = bcd;
    assign bus4.lz_blank = lz;
    assign bus1.en       = en;
    assign bus1.load     = load;
    assign bus1.bcd      = bcd[3:0];
    assign bus1.lz_blank = lz;

    sevenseg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    sevenseg_scan_driver #(.DIGITS(1), .REFRESH_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1001111, 7'b1001111,
        7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111
    };

    typedef struct {
        int unsigned n;        // enabled cycles since reset, modulo one frame
        logic [31:0] disp;
        logic [31:0] pend;
        logic        pending;
    } mstate_t;

    typedef struct {
        logic [6:0] seg;
        logic [7:0] an;
        logic       fd;
        logic       pending;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t    q4[$];
    exp_t    q1[$];
    mstate_t s4;
    mstate_t s1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Digit index and frame position come straight from the count of enabled cycles.
    task automatic model_step(input int d, input int r, input logic e_en, input logic e_ld,
                              input logic e_lz, input logic [31:0] b,
                              input mstate_t si, output mstate_t so, output exp_t ex);
        int          idx;
        int unsigned dr;
        logic        wrap;
        logic [3:0]  dig;
        so   = si;
        dr   = d * r;
        idx  = int'((si.n / r) % d);
        dig  = 4'(si.disp >> (4 * idx));
        ex.an  = e_en ? 8'(1 << idx) : 8'd0;
        ex.seg = (!e_en || (e_lz && idx > 0 && (si.disp >> (4 * idx)) == 0)) ? 7'd0 : SEG_TAB[dig];
        wrap = e_en && ((si.n % dr) == dr - 1);
        if (e_en) so.n = (si.n + 1) % dr;
        if (e_ld) so.pend = b;
        if (wrap) begin
            so.disp    = e_ld ? b : (si.pending ? si.pend : si.disp);
            so.pending = 1'b0;
        end else if (e_ld) begin
            so.pending = 1'b1;
        end
        ex.fd      = wrap;
        ex.pending = so.pending;
    endtask

    initial begin : model
        exp_t    e;
        mstate_t t;
        forever begin
            @(posedge clk);
            if (reset) begin
                s4 = '{default: 0};
                s1 = '{default: 0};
                e  = '{default: 0};
                q4.push_back(e);
                q1.push_back(e);
            end else begin
                model_step(4, 4, en, load, lz, {16'd0, bcd}, s4, t, e);
                s4 = t;
                q4.push_back(e);
                model_step(1, 1, en, load, lz, {28'd0, bcd[3:0]}, s1, t, e);
                s1 = t;
                q1.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("seg4", 32'(bus4.seg), 32'(e.seg));
                check("an4", 32'(bus4.an), 32'(e.an[3:0]));
                check("frame_done4", 32'(bus4.frame_done), 32'(e.fd));
                check("pending4", 32'(bus4.pending), 32'(e.pending));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("seg1", 32'(bus1.seg), 32'(e.seg));
                check("an1", 32'(bus1.an), 32'(e.an[0]));
                check("frame_done1", 32'(bus1.frame_done), 32'(e.fd));
                check("pending1", 32'(bus1.pending), 32'(e.pending));
            end
        end
    end

    task automatic drive(input logic e, input logic l, input logic z, input logic [15:0] b);
        en   = e;
        load = l;
        lz   = z;
        bcd  = b;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int n, input logic e, input logic z);
        repeat (n) drive(e, 1'b0, z, bcd);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

    initial begin : stim
        logic re, rl, rz;
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        lz    = 1'b0;
        bcd   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        drive(1'b1, 1'b1, 1'b0, 16'h1234);
        run(40, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, sweep[k]);
            run(20, 1'b1, 1'b0);
        end

        drive(1'b1, 1'b1, 1'b1, 16'h0050);
        run(20, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 16'h0000);
        run(20, 1'b1, 1'b1);
        run(20, 1'b1, 1'b0);

        run(5, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'h9999);
        run(20, 1'b1, 1'b0);

        run(6, 1'b1, 1'b0);
        run(4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 16'h4321);
        run(5, 1'b0, 1'b0);
        run(30, 1'b1, 1'b0);

        rz = 1'b0;
        repeat (600) begin
            re = ($urandom_range(0, 9) != 0);
            rl = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) rz = ~rz;
            drive(re, rl, rz, rand_bcd());
        end

        // Asynchronous reset mid-frame: outputs must clear before the next edge.
        drive(1'b1, 1'b1, 1'b0, 16'h8888);
        run(21, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        q4.delete();
        q1.delete();
        #1;
        check("async_seg4", 32'(bus4.seg), 32'd0);
        check("async_an4", 32'(bus4.an), 32'd0);
        check("async_fd4", 32'(bus4.frame_done), 32'd0);
        check("async_pending4", 32'(bus4.pending), 32'd0);
        check("async_seg1", 32'(bus1.seg), 32'd0);
        check("async_an1", 32'(bus1.an), 32'd0);
        run(2, 1'b1, 1'b0);
        reset = 1'b0;
        run(30, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
